// File: rtl/seg7_capture_if.sv
// Segment-bus capture interface: the display side drives the multiplexed bus,
// the capture block returns the recovered digits and update strobes.
interface seg7_capture_if #(
  parameter int NUM_DIGITS = 6
);
  logic [6:0]              seg_in;
  logic [2:0]              digit_sel;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dig_valid;
  logic [NUM_DIGITS-1:0]   dig_err;
  logic                    upd_valid;
  logic [2:0]              upd_idx;
  logic                    frame_done;

  modport master (
    output seg_in, digit_sel, clear,
    input  value, dig_valid, dig_err, upd_valid, upd_idx, frame_done
  );

  modport slave (
    input  seg_in, digit_sel, clear,
    output value, dig_valid, dig_err, upd_valid, upd_idx, frame_done
  );
endinterface

// File: rtl/seg7_capture.sv
// Recovers per-digit nibbles from a time-multiplexed active-low 7-segment bus,
// capturing a digit only once its {digit_sel, seg_in} pair has been stable long enough.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 6
) (
  input logic           clock,
  input logic           resetn,
  seg7_capture_if.slave bus
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {TRACK, HOLD} state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] nib;
  } glyph_t;

  function automatic glyph_t decode(input logic [6:0] seg);
    glyph_t g;
    g.legal = 1'b1;
    case (seg)
      7'h40:   g.nib = 4'h0;
      7'h79:   g.nib = 4'h1;
      7'h24:   g.nib = 4'h2;
      7'h30:   g.nib = 4'h3;
      7'h19:   g.nib = 4'h4;
      7'h12:   g.nib = 4'h5;
      7'h02:   g.nib = 4'h6;
      7'h78:   g.nib = 4'h7;
      7'h00:   g.nib = 4'h8;
      7'h10:   g.nib = 4'h9;
      7'h08:   g.nib = 4'hA;
      7'h03:   g.nib = 4'hB;
      7'h46:   g.nib = 4'hC;
      7'h21:   g.nib = 4'hD;
      7'h06:   g.nib = 4'hE;
      7'h0E:   g.nib = 4'hF;
      default: begin
        g.nib   = 4'h0;
        g.legal = 1'b0;
      end
    endcase
    return g;
  endfunction

  logic [6:0]              seg_q;
  logic [2:0]              sel_q;
  logic [CW-1:0]           cnt;
  state_t                  state;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic [NUM_DIGITS-1:0]   err_q;
  logic                    upd_valid_q;
  logic [2:0]              upd_idx_q;
  logic                    frame_q;

  logic                    same;
  logic                    hit;
  logic                    capture;
  glyph_t                  glyph;
  logic [4*NUM_DIGITS-1:0] value_nxt;
  logic [NUM_DIGITS-1:0]   valid_nxt;
  logic [NUM_DIGITS-1:0]   err_nxt;

  assign same  = ({bus.digit_sel, bus.seg_in} == {sel_q, seg_q});
  assign hit   = (state == TRACK) && (cnt == CNT_MAX);
  assign glyph = decode(seg_q);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    capture   = 1'b0;
    value_nxt = value_q;
    valid_nxt = valid_q;
    err_nxt   = err_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (hit && sel_q == 3'(i)) begin
        capture = 1'b1;
        if (seg_q == 7'h7F) begin
          valid_nxt[i] = 1'b0;
          err_nxt[i]   = 1'b0;
        end else if (glyph.legal) begin
          value_nxt[4*i +: 4] = glyph.nib;
          valid_nxt[i]        = 1'b1;
          err_nxt[i]          = 1'b0;
        end else begin
          valid_nxt[i] = 1'b0;
          err_nxt[i]   = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_q       <= 7'h7F;
      sel_q       <= 3'd7;
      cnt         <= '0;
      state       <= TRACK;
      value_q     <= '0;
      valid_q     <= '0;
      err_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= 3'd0;
      frame_q     <= 1'b0;
    end else begin
      seg_q <= bus.seg_in;
      sel_q <= bus.digit_sel;
      if (bus.clear) begin
        // Clear outranks a capture landing on the same edge; upd_idx keeps its last value.
        value_q     <= '0;
        valid_q     <= '0;
        err_q       <= '0;
        upd_valid_q <= 1'b0;
        frame_q     <= 1'b0;
        cnt         <= '0;
        state       <= TRACK;
      end else begin
        value_q     <= value_nxt;
        valid_q     <= valid_nxt;
        err_q       <= err_nxt;
        upd_valid_q <= capture;
        if (capture) upd_idx_q <= sel_q;
        frame_q     <= (&valid_nxt) && !(&valid_q);
        if (!same) begin
          // A new pair always restarts tracking, even on the edge that captures the old one.
          cnt   <= CNT_ONE;
          state <= TRACK;
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
          if (hit) state <= HOLD;
        end
      end
    end
  end

  assign bus.value      = value_q;
  assign bus.dig_valid  = valid_q;
  assign bus.dig_err    = err_q;
  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_idx    = upd_idx_q;
  assign bus.frame_done = frame_q;

endmodule
